// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t    : fetch FSM state encoding
//   BRANCH_BIT : position of the Branch flag inside the control word
//   PC_INC     : sequential program-counter increment in bytes
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam int          CTRL_W     = 9;
    localparam int          BRANCH_BIT = 2;
    localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port.
//   imem_req   : fetch unit -> memory, read request
//   imem_addr  : fetch unit -> memory, byte address
//   imem_ack   : memory -> fetch unit, imem_rdata valid this cycle
//   imem_rdata : memory -> fetch unit, instruction word
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_branch_target.sv
// Branch-target adder: target = pc + 4 + (sign-extended imm16 << 2), modulo 2^32.
//   pc     : current program counter
//   imm16  : branch offset field, in instruction words
//   target : taken-branch destination
module branch_target
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    output logic [31:0] target
);
    logic [31:0] offset;

    assign offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign target = pc + PC_INC + offset;
endmodule

// File: rtl/instr_fetch.sv
// Three-state instruction fetch unit.
//   clk, rst    : clock and synchronous active-high reset
//   imem        : instruction-memory read port (master side)
//   opcode      : instr[31:26] for the control unit
//   instr       : latched instruction register
//   instr_valid : instr/opcode meaningful (DECODE and EXEC)
//   ctrl_word   : registered control word; Branch flag at BRANCH_BIT
//   alu_zero    : ALU zero flag for the current instruction
//   stall       : holds the unit in EXEC
//   pc          : current program counter
//
// state  | meaning
// FETCH  | request imem at pc, latch instr on ack
// DECODE | one cycle for the registered control unit to respond
// EXEC   | ctrl_word valid; update pc and return to FETCH unless stalled
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_if.master       imem,
    output logic [5:0]          opcode,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic [CTRL_W-1:0]   ctrl_word,
    input  logic                alu_zero,
    input  logic                stall,
    output logic [31:0]         pc
);
    state_t      state;
    logic        req_q;
    logic        valid_q;
    logic [31:0] target;
    logic        taken;
    logic        unused_ctrl;

    branch_target u_branch_target (
        .pc     (pc),
        .imm16  (instr[15:0]),
        .target (target)
    );

    assign taken       = ctrl_word[BRANCH_BIT] & alu_zero;
    assign unused_ctrl = ^{ctrl_word[CTRL_W-1:BRANCH_BIT+1], ctrl_word[BRANCH_BIT-1:0]};

    // req/valid are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            instr   <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr   <= imem.imem_rdata;
                        state   <= DECODE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                DECODE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        pc      <= taken ? target : pc + PC_INC;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign instr_valid    = valid_q;
    assign opcode         = instr[31:26];
endmodule
